queens_sweep_ctrl: RTL and testbench
====================================

Name: queens_sweep_ctrl

Overview:
- Sequencer for the N-queens counting solver.
- Sweeps board size n over a programmed range [n_lo, n_hi], running the solver once per n: clear, run, wait for finish, capture solution count.
- Streams each size's first solution out over a valid/ready port.
- Sits between the board-level host/UI logic and a single solver instance; owns the solver's reset, n and row_query inputs.

Parameters:
- NMAX, 24, largest legal board size; the solver's first_solution capture holds 24 columns.
- CLR_CYCLES, 2, cycles solver_reset is held high before each run.
- MAX_CYCLES, 32'hFFFF_FFF0, per-run cycle budget before timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begin sweep (ignored while busy)
- n_lo  in  5  first board size, sampled at start
- n_hi  in  5  last board size, sampled at start
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- err  out  1  range invalid at last start; held until next start
- timeout  out  1  sticky: some run hit MAX_CYCLES; cleared at start
- solver_reset  out  1  drives the solver's reset
- solver_n  out  5  drives the solver's n
- solver_result  in  32  solver solution count
- solver_finished  in  1  solver's finished flag, exported as a port
- solver_row_query  out  5  drives the solver's row_query
- solver_row_result  in  5  solver row for the queried column; 1-based, combinational
- sol_valid  out  1  solution stream valid
- sol_ready  in  1  solution stream ready
- sol_n  out  5  board size of current beat
- sol_col  out  5  column index
- sol_row  out  5  0-based queen row
- sol_last  out  1  final column of this n
- rd_n  in  5  count-table read address
- rd_count  out  32  count-table data, 1-cycle registered latency
- run_cycles  out  32  cycle count of the most recent run

Behaviour:
- Reset values:
  - busy=0, done=0, err=0, timeout=0, sol_valid=0, sol_last=0, sol_n/col/row=0
  - solver_reset=1, solver_n=0, solver_row_query=0, run_cycles=0, rd_count=0
  - count table all 0
- Reset mid-sweep aborts immediately; the solver is held in reset.
- States: IDLE, CLEAR, RUN, CAPTURE, DUMP, NEXT.
- IDLE:
  - solver_reset=1.
  - On start: latch n_lo/n_hi, clear err/timeout.
  - If n_lo==0, n_hi>NMAX, or n_lo>n_hi: set err, pulse done the next cycle, stay IDLE.
  - Otherwise: cur_n=n_lo, busy=1, go CLEAR.
- CLEAR:
  - solver_n=cur_n, solver_reset=1 for exactly CLR_CYCLES cycles.
  - solver_n must be stable at least 1 cycle before solver_reset falls and throughout RUN.
  - Then go RUN.
- RUN:
  - solver_reset=0; cycle counter starts at 0 on the first RUN cycle.
  - When solver_finished=1, go CAPTURE.
  - If the counter reaches MAX_CYCLES first: set timeout, capture count 32'hFFFF_FFFF, skip DUMP, go NEXT.
- CAPTURE (1 cycle):
  - table[cur_n] <= solver_result; run_cycles <= counter.
  - If solver_result==0, go NEXT; otherwise col=0, go DUMP.
- DUMP:
  - solver_row_query=col.
  - sol_row = solver_row_result-1 (5-bit), sol_col=col, sol_n=cur_n, sol_last=(col==cur_n-1).
  - Outputs registered; valid rises 1 cycle after query.
  - A beat transfers when sol_valid && sol_ready.
  - Payload must hold stable while valid && !ready.
  - After the last beat transfers, go NEXT.
- NEXT:
  - If cur_n==n_hi: busy=0, pulse done, go IDLE.
  - Otherwise cur_n+1, go CLEAR.
- Solver stays in reset between runs, so its stale first_solution is never read outside DUMP.
- Count table:
  - 32x32, indexed by n; entries outside the sweep keep prior values.
  - A read of an address being written the same cycle returns the new value.
- start while busy: no effect.
- sol_ready held low indefinitely: stall in DUMP; no timeout applies to DUMP.

Decomposition:
- Shared package queens_pkg: NMAX, width constants (N_W=5, CNT_W=32), state enum type, TIMEOUT_COUNT constant 32'hFFFF_FFFF.
- One sub-module is natural: queens_count_table (32x32 register file, one write port, registered read port with write-through).

Test Plan:
- start, n_lo=n_hi=4 -> count 2; stream (col,row) = (0,1)(1,3)(2,0)(3,2) with last on col 3; done pulses once; rd_n=4 gives 2.
- start, n_lo=1, n_hi=8 -> counts 1,0,0,2,10,4,40,92; no beats for n=2,3; n=8 rows 0,4,7,5,2,6,1,3.
- n_lo=6, n_hi=6 with sol_ready toggling 1-0-0-1 randomly -> rows 1,3,5,0,2,4, each held stable while stalled; count 4.
- n_lo=5, n_hi=3 -> err=1, done pulse, busy never asserts, solver_reset stays 1.
- MAX_CYCLES=50, n=8 -> timeout=1, table[8]=32'hFFFF_FFFF, no stream beats, sweep completes.
- reset asserted during DUMP of n=5 -> next cycle busy=0, sol_valid=0, solver_reset=1; a new start of 4..4 gives count 2.

Source files
------------

// File: rtl/queens_pkg.sv
// Shared types and constants for the N-queens sweep sequencer.
//   NMAX          : largest legal board size
//   N_W / CNT_W   : board-size and count widths
//   TIMEOUT_COUNT : count recorded for a run that never finished
//   state_t       : sequencer states
//   range_bad()   : true when a programmed [lo, hi] sweep range is illegal
package queens_pkg;

    localparam int unsigned NMAX      = 24;
    localparam int unsigned N_W       = 5;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned TBL_DEPTH = 32;
    localparam int unsigned CLR_W     = 8;

    localparam logic [CNT_W-1:0] TIMEOUT_COUNT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CAPTURE,
        S_DUMP,
        S_NEXT
    } state_t;

    // Illegal when the sweep starts at 0, exceeds NMAX, or is reversed.
    function automatic logic range_bad(input logic [N_W-1:0] lo,
                                       input logic [N_W-1:0] hi);
        return (lo == '0) || (hi > N_W'(NMAX)) || (lo > hi);
    endfunction

endpackage

// File: rtl/queens_count_table.sv
// Per-board-size solution count table.
//   clk, reset       : clock, synchronous active-high reset (clears all entries)
//   we, wr_addr,
//   wr_data          : single write port
//   rd_addr, rd_data : registered read port, 1-cycle latency, write-through
module queens_count_table
    import queens_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [N_W-1:0]   wr_addr,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [N_W-1:0]   rd_addr,
    output logic [CNT_W-1:0] rd_data
);

    logic [CNT_W-1:0] mem [TBL_DEPTH];

    // Storage and read register; a same-cycle write to the read address is forwarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (we) begin
                mem[wr_addr] <= wr_data;
            end
            rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/queens_sweep_ctrl.sv
// Sequencer that sweeps board size over [n_lo, n_hi], runs the N-queens solver
// once per size, records the solution count and streams the first solution.
//   clk, reset                  : clock, synchronous active-high reset
//   start, n_lo, n_hi           : sweep request and range
//   busy, done, err, timeout    : sweep status
//   solver_*                    : control/observation of the single solver instance
//   sol_valid/ready/n/col/row/last : first-solution stream (one beat per column)
//   rd_n, rd_count              : count-table read port (1-cycle latency)
//   run_cycles                  : cycle count of the most recent run
module queens_sweep_ctrl
    import queens_pkg::*;
#(
    parameter int unsigned      CLR_CYCLES = 2,
    parameter logic [CNT_W-1:0] MAX_CYCLES = 32'hFFFF_FFF0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_W-1:0]   n_lo,
    input  logic [N_W-1:0]   n_hi,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             timeout,
    output logic             solver_reset,
    output logic [N_W-1:0]   solver_n,
    input  logic [CNT_W-1:0] solver_result,
    input  logic             solver_finished,
    output logic [N_W-1:0]   solver_row_query,
    input  logic [N_W-1:0]   solver_row_result,
    output logic             sol_valid,
    input  logic             sol_ready,
    output logic [N_W-1:0]   sol_n,
    output logic [N_W-1:0]   sol_col,
    output logic [N_W-1:0]   sol_row,
    output logic             sol_last,
    input  logic [N_W-1:0]   rd_n,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] run_cycles
);

    state_t           state;
    logic [N_W-1:0]   hi_q;
    logic [N_W-1:0]   cur_n;
    logic [N_W-1:0]   col;
    logic [CLR_W-1:0] clr_cnt;
    logic [CNT_W-1:0] cyc_cnt;

    logic             run_expired_c;
    logic             tbl_we_c;
    logic [CNT_W-1:0] tbl_wdata_c;

    // Budget exhausted without the solver finishing.
    assign run_expired_c = (state == S_RUN) && !solver_finished && (cyc_cnt == MAX_CYCLES);

    // Table writes: real count at CAPTURE, sentinel on an expired run.
    assign tbl_we_c    = (state == S_CAPTURE) || run_expired_c;
    assign tbl_wdata_c = run_expired_c ? TIMEOUT_COUNT : solver_result;

    queens_count_table u_table (
        .clk     (clk),
        .reset   (reset),
        .we      (tbl_we_c),
        .wr_addr (cur_n),
        .wr_data (tbl_wdata_c),
        .rd_addr (rd_n),
        .rd_data (rd_count)
    );

    // Sweep sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            hi_q             <= '0;
            cur_n            <= '0;
            col              <= '0;
            clr_cnt          <= '0;
            cyc_cnt          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            timeout          <= 1'b0;
            solver_reset     <= 1'b1;
            solver_n         <= '0;
            solver_row_query <= '0;
            sol_valid        <= 1'b0;
            sol_n            <= '0;
            sol_col          <= '0;
            sol_row          <= '0;
            sol_last         <= 1'b0;
            run_cycles       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    solver_reset <= 1'b1;
                    if (start) begin
                        hi_q    <= n_hi;
                        timeout <= 1'b0;
                        if (range_bad(n_lo, n_hi)) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            err      <= 1'b0;
                            cur_n    <= n_lo;
                            solver_n <= n_lo;
                            busy     <= 1'b1;
                            clr_cnt  <= '0;
                            state    <= S_CLEAR;
                        end
                    end
                end

                // solver_n was loaded on entry, so it leads the reset release.
                S_CLEAR: begin
                    if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
                        solver_reset <= 1'b0;
                        cyc_cnt      <= '0;
                        state        <= S_RUN;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    if (solver_finished) begin
                        state <= S_CAPTURE;
                    end else if (run_expired_c) begin
                        timeout      <= 1'b1;
                        run_cycles   <= cyc_cnt;
                        solver_reset <= 1'b1;
                        state        <= S_NEXT;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                S_CAPTURE: begin
                    run_cycles <= cyc_cnt;
                    if (solver_result == '0) begin
                        solver_reset <= 1'b1;
                        state        <= S_NEXT;
                    end else begin
                        col              <= '0;
                        solver_row_query <= '0;
                        state            <= S_DUMP;
                    end
                end

                // One beat per column: load while idle, hold until accepted, then re-query.
                S_DUMP: begin
                    if (!sol_valid) begin
                        sol_valid <= 1'b1;
                        sol_n     <= cur_n;
                        sol_col   <= col;
                        sol_row   <= solver_row_result - 5'd1;
                        sol_last  <= (col == cur_n - 5'd1);
                    end else if (sol_ready) begin
                        sol_valid <= 1'b0;
                        if (sol_last) begin
                            solver_reset <= 1'b1;
                            state        <= S_NEXT;
                        end else begin
                            col              <= col + 5'd1;
                            solver_row_query <= col + 5'd1;
                        end
                    end
                end

                S_NEXT: begin
                    if (cur_n == hi_q) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cur_n    <= cur_n + 5'd1;
                        solver_n <= cur_n + 5'd1;
                        clr_cnt  <= '0;
                        state    <= S_CLEAR;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_queens_sweep_ctrl.sv
// Directed bench for queens_sweep_ctrl with a behavioural solver model.
module tb_queens_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  n_lo = '0;
    logic [4:0]  n_hi = '0;
    logic [4:0]  rd_n = '0;
    logic        sol_ready = 1'b1;

    logic        busy, done, err, timeout, solver_reset, solver_finished;
    logic [4:0]  solver_n, solver_row_query, solver_row_result;
    logic [31:0] solver_result, rd_count, run_cycles;
    logic        sol_valid, sol_last;
    logic [4:0]  sol_n, sol_col, sol_row;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    queens_sweep_ctrl #(.CLR_CYCLES(2), .MAX_CYCLES(32'd50)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .n_lo              (n_lo),
        .n_hi              (n_hi),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .timeout           (timeout),
        .solver_reset      (solver_reset),
        .solver_n          (solver_n),
        .solver_result     (solver_result),
        .solver_finished   (solver_finished),
        .solver_row_query  (solver_row_query),
        .solver_row_result (solver_row_result),
        .sol_valid         (sol_valid),
        .sol_ready         (sol_ready),
        .sol_n             (sol_n),
        .sol_col           (sol_col),
        .sol_row           (sol_row),
        .sol_last          (sol_last),
        .rd_n              (rd_n),
        .rd_count          (rd_count),
        .run_cycles        (run_cycles)
    );

    // Known results for n = 0..8: counts and first (lexicographic) solution, 0-based rows.
    int cnt_tab [0:8] = '{0, 1, 0, 0, 2, 10, 4, 40, 92};
    int sol0 [0:8][0:7] = '{
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{0, 0, 0, 0, 0, 0, 0, 0},
        '{1, 3, 0, 2, 0, 0, 0, 0},
        '{0, 2, 4, 1, 3, 0, 0, 0},
        '{1, 3, 5, 0, 2, 4, 0, 0},
        '{0, 2, 4, 6, 1, 3, 5, 0},
        '{0, 4, 7, 5, 2, 6, 1, 3}
    };

    // Solver model: finishes n+4 cycles after reset release unless hang is set.
    logic hang = 1'b0;
    logic fin  = 1'b0;
    int   mcnt = 0;

    always @(posedge clk) begin
        if (solver_reset === 1'b1) begin
            mcnt <= 0;
            fin  <= 1'b0;
        end else begin
            mcnt <= mcnt + 1;
            if (!hang && (mcnt == int'(solver_n) + 3)) fin <= 1'b1;
        end
    end

    assign solver_finished = fin;

    always_comb begin
        int nn;
        int qq;
        nn = int'(solver_n);
        qq = int'(solver_row_query);
        solver_result     = 32'hDEAD_BEEF;
        solver_row_result = 5'd0;
        if (fin && nn <= 8) solver_result = 32'(cnt_tab[nn]);
        if (nn <= 8 && qq < nn) solver_row_result = 5'(sol0[nn][qq] + 1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream monitor, ready driver and status trackers, all on the falling edge.
    logic [15:0] beats [$];
    logic [15:0] pay;
    logic [15:0] prev_pay = '0;
    logic        prev_stall = 1'b0;
    logic [4:0]  prev_sn = '0;
    logic        prev_ok = 1'b0;
    int          done_cnt = 0;
    logic        busy_seen = 1'b0;
    logic        srst_low_seen = 1'b0;
    int          ready_mode = 0;

    assign pay = {sol_n, sol_col, sol_row, sol_last};

    always @(negedge clk) begin
        sol_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (!reset) begin
            if (prev_stall) check("stall_hold", 32'(pay), 32'(prev_pay));
            if (sol_valid && sol_ready) beats.push_back(pay);
            prev_stall = sol_valid && !sol_ready;
            prev_pay   = pay;
            if (prev_ok && !solver_reset) check("solver_n_stable", 32'(solver_n), 32'(prev_sn));
            prev_sn = solver_n;
            prev_ok = 1'b1;
            if (done) done_cnt++;
            if (busy) busy_seen = 1'b1;
            if (!solver_reset) srst_low_seen = 1'b1;
        end else begin
            prev_stall = 1'b0;
            prev_ok    = 1'b0;
        end
    end

    task automatic do_start(input int lo, input int hi);
        @(negedge clk);
        n_lo  = 5'(lo);
        n_hi  = 5'(hi);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_within_budget", 32'(done), 32'd1);
    endtask

    task automatic read_cnt(input int n, input logic [31:0] exp);
        @(negedge clk);
        rd_n = 5'(n);
        @(negedge clk);
        check($sformatf("count_n%0d", n), rd_count, exp);
    endtask

    task automatic check_stream(input int lo, input int hi);
        logic [15:0] exp_q [$];
        for (int n = lo; n <= hi; n++) begin
            if (cnt_tab[n] != 0) begin
                for (int c = 0; c < n; c++) begin
                    exp_q.push_back({5'(n), 5'(c), 5'(sol0[n][c]), (c == n - 1)});
                end
            end
        end
        check("beat_count", 32'(beats.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < beats.size()) check($sformatf("beat%0d", i), 32'(beats[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic settle_done_once();
        repeat (3) @(negedge clk);
        check("done_low_after", 32'(done), 32'd0);
        check("done_once", 32'(done_cnt), 32'd1);
        check("busy_low_after", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] last_rd;
        int k;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_solver_reset", 32'(solver_reset), 32'd1);
        check("rst_solver_n", 32'(solver_n), 32'd0);
        check("rst_row_query", 32'(solver_row_query), 32'd0);
        check("rst_sol_valid", 32'(sol_valid), 32'd0);
        check("rst_sol_payload", 32'(pay), 32'd0);
        check("rst_run_cycles", run_cycles, 32'd0);
        check("rst_rd_count", rd_count, 32'd0);

        // Single size n=4, with write-through observed on rd_n=4
        rd_n = 5'd4;
        done_cnt = 0;
        beats.delete();
        do_start(4, 4);
        check("busy_after_start", 32'(busy), 32'd1);
        last_rd = rd_count;
        k = 0;
        while (!sol_valid && k < 200) begin
            last_rd = rd_count;
            @(negedge clk);
            k++;
        end
        check("write_through", last_rd, 32'd2);
        wait_done(200);
        settle_done_once();
        check_stream(4, 4);
        check("run_cycles_n4", run_cycles, 32'd8);
        read_cnt(4, 32'd2);

        // Sweep 1..8
        done_cnt = 0;
        beats.delete();
        do_start(1, 8);
        wait_done(2000);
        settle_done_once();
        check_stream(1, 8);
        for (int n = 1; n <= 8; n++) read_cnt(n, 32'(cnt_tab[n]));

        // n=6 with a randomly stalling consumer
        ready_mode = 1;
        done_cnt = 0;
        beats.delete();
        do_start(6, 6);
        wait_done(500);
        ready_mode = 0;
        settle_done_once();
        check_stream(6, 6);
        read_cnt(6, 32'd4);

        // Reversed range
        repeat (2) @(negedge clk);
        done_cnt = 0;
        busy_seen = 1'b0;
        srst_low_seen = 1'b0;
        do_start(5, 3);
        check("err_rev", 32'(err), 32'd1);
        check("done_rev", 32'(done), 32'd1);
        check("busy_rev", 32'(busy), 32'd0);
        settle_done_once();
        check("busy_never_rev", 32'(busy_seen), 32'd0);
        check("srst_held_rev", 32'(srst_low_seen), 32'd0);
        check("err_held", 32'(err), 32'd1);

        // Zero low bound and above-NMAX high bound
        do_start(0, 4);
        check("err_lo0", 32'(err), 32'd1);
        check("done_lo0", 32'(done), 32'd1);
        do_start(1, 25);
        check("err_hi25", 32'(err), 32'd1);
        repeat (2) @(negedge clk);
        check("busy_never_bad", 32'(busy_seen), 32'd0);

        // Solver hangs on n=8: budget expires
        hang = 1'b1;
        done_cnt = 0;
        beats.delete();
        do_start(8, 8);
        check("err_cleared", 32'(err), 32'd0);
        wait_done(400);
        hang = 1'b0;
        settle_done_once();
        check("timeout_set", 32'(timeout), 32'd1);
        check("timeout_no_beats", 32'(beats.size()), 32'd0);
        read_cnt(8, 32'hFFFF_FFFF);
        read_cnt(7, 32'd40);

        // Reset during the n=5 dump, then recover
        done_cnt = 0;
        beats.delete();
        do_start(5, 5);
        check("timeout_cleared", 32'(timeout), 32'd0);
        k = 0;
        while (beats.size() < 2 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("reached_dump", 32'(beats.size() >= 2), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(sol_valid), 32'd0);
        check("abort_solver_reset", 32'(solver_reset), 32'd1);
        reset = 1'b0;
        read_cnt(5, 32'd0);
        done_cnt = 0;
        beats.delete();
        do_start(4, 4);
        wait_done(200);
        settle_done_once();
        check_stream(4, 4);
        read_cnt(4, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
